// File: rtl/load_store_unit.sv
// load_store_unit
//
// Memory-access stage that sits after the ALU. The ALU result is the
// effective byte address and rs2 is the store data. A legal load or store
// becomes one request/acknowledge transaction on the data-memory bus, and
// the core is stalled until that transaction finishes. Byte and halfword
// accesses are placed on the correct byte lanes. Loads are sign- or
// zero-extended. Misaligned or illegal accesses are flagged without ever
// touching the bus.
//
// Optional feature: define LSU_TIMEOUT_EN to abort a request that gets no
// acknowledge within TIMEOUT_CYCLES REQ cycles. The abort pulses o_BusError
// during DONE. When the macro is undefined, REQ waits for ever and
// o_BusError is tied low.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_ALUResult           effective byte address
//   i_WriteData           store data (rs2)
//   i_MemRead/i_MemWrite  load / store present
//   i_Funct3              size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   o_ReadData            registered, extended load result
//   o_Stall               hold PC/instruction while the access is pending
//   o_MisalignedFault     illegal or misaligned access (IDLE only)
//   o_BusError            timeout abort, one-cycle pulse in DONE
//   o_BusReq/o_BusWe      bus request, 1 = write
//   o_BusAddr             word-aligned address
//   o_BusWData            lane-replicated store data
//   o_BusByteEn           active byte lanes
//   i_BusAck/i_BusRData   acknowledge and read word (valid with ack)

module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ALUResult,
  input  logic [31:0] i_WriteData,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [2:0]  i_Funct3,
  output logic [31:0] o_ReadData,
  output logic        o_Stall,
  output logic        o_MisalignedFault,
  output logic        o_BusError,
  output logic        o_BusReq,
  output logic        o_BusWe,
  output logic [31:0] o_BusAddr,
  output logic [31:0] o_BusWData,
  output logic [3:0]  o_BusByteEn,
  input  logic        i_BusAck,
  input  logic [31:0] i_BusRData
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [1:0]  lane_off;
  logic [2:0]  funct3_q;

  logic        access;
  logic        illegal;
  logic        legal_access;
  logic [3:0]  byte_en_next;
  logic [31:0] wdata_next;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;

  // Decode the incoming instruction. Any condition that makes the access
  // illegal is accumulated into one flag. Lane enables and replicated
  // store data depend only on the size bits.
  always_comb begin
    access  = i_MemRead ^ i_MemWrite;
    illegal = 1'b0;

    if (i_MemRead && i_MemWrite)
      illegal = 1'b1;

    if (i_MemWrite && !i_MemRead) begin
      case (i_Funct3)
        3'b000, 3'b001, 3'b010: illegal = illegal;
        default:                illegal = 1'b1;
      endcase
    end

    if (i_MemRead && !i_MemWrite) begin
      case (i_Funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = illegal;
        default:                                illegal = 1'b1;
      endcase
    end

    // Halfword needs an even address. Word needs a 4-byte-aligned address.
    if ((i_MemRead || i_MemWrite) && (i_Funct3[1:0] == 2'b01) && i_ALUResult[0])
      illegal = 1'b1;
    if ((i_MemRead || i_MemWrite) && (i_Funct3[1:0] == 2'b10) && (i_ALUResult[1:0] != 2'b00))
      illegal = 1'b1;

    legal_access = access && !illegal;

    case (i_Funct3[1:0])
      2'b00: begin
        byte_en_next = 4'b0001 << i_ALUResult[1:0];
        wdata_next   = {4{i_WriteData[7:0]}};
      end
      2'b01: begin
        byte_en_next = 4'b0011 << i_ALUResult[1:0];
        wdata_next   = {2{i_WriteData[15:0]}};
      end
      default: begin
        byte_en_next = 4'b1111;
        wdata_next   = i_WriteData;
      end
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it. The
  // lane offset and size were latched when the request started, so a
  // late change on the address inputs cannot corrupt the result.
  always_comb begin
    case (lane_off)
      2'd0:    load_byte = i_BusRData[7:0];
      2'd1:    load_byte = i_BusRData[15:8];
      2'd2:    load_byte = i_BusRData[23:16];
      default: load_byte = i_BusRData[31:24];
    endcase
    load_half = lane_off[1] ? i_BusRData[31:16] : i_BusRData[15:0];

    case (funct3_q)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b100:  load_value = {24'h000000, load_byte};
      3'b101:  load_value = {16'h0000, load_half};
      default: load_value = i_BusRData;
    endcase
  end

  // DONE is the cycle in which the core moves past the instruction, so the
  // stall drops there even though the access inputs are still present.
  assign o_Stall           = legal_access && (state != DONE);
  assign o_MisalignedFault = (state == IDLE) && illegal;

`ifdef LSU_TIMEOUT_EN
  localparam int COUNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [COUNT_W-1:0] wait_count;
  logic               bus_error_q;

  assign o_BusError = bus_error_q;

  // Transaction FSM with a wait counter. The counter holds the number of
  // ack-less REQ cycles already completed. When it equals TIMEOUT_CYCLES-1
  // with no ack, the current cycle is the TIMEOUT_CYCLES-th one and the
  // request is abandoned. An ack in that same cycle still wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      o_BusReq    <= 1'b0;
      o_BusWe     <= 1'b0;
      o_BusAddr   <= 32'h0;
      o_BusWData  <= 32'h0;
      o_BusByteEn <= 4'b0000;
      o_ReadData  <= 32'h0;
      lane_off    <= 2'b00;
      funct3_q    <= 3'b000;
      wait_count  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus_error_q <= 1'b0;
          if (legal_access) begin
            o_BusAddr   <= {i_ALUResult[31:2], 2'b00};
            o_BusByteEn <= byte_en_next;
            o_BusWData  <= wdata_next;
            o_BusWe     <= i_MemWrite;
            lane_off    <= i_ALUResult[1:0];
            funct3_q    <= i_Funct3;
            wait_count  <= '0;
            o_BusReq    <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (i_BusAck) begin
            if (!o_BusWe)
              o_ReadData <= load_value;
            o_BusReq <= 1'b0;
            state    <= DONE;
          end else if (wait_count == COUNT_W'(TIMEOUT_CYCLES - 1)) begin
            o_BusReq    <= 1'b0;
            o_ReadData  <= 32'h0;
            bus_error_q <= 1'b1;
            state       <= DONE;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        DONE: begin
          bus_error_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign o_BusError            = 1'b0;

  // Transaction FSM. Bus outputs stay registered and stable for the whole
  // REQ phase. The request waits indefinitely for the acknowledge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      o_BusReq    <= 1'b0;
      o_BusWe     <= 1'b0;
      o_BusAddr   <= 32'h0;
      o_BusWData  <= 32'h0;
      o_BusByteEn <= 4'b0000;
      o_ReadData  <= 32'h0;
      lane_off    <= 2'b00;
      funct3_q    <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (legal_access) begin
            o_BusAddr   <= {i_ALUResult[31:2], 2'b00};
            o_BusByteEn <= byte_en_next;
            o_BusWData  <= wdata_next;
            o_BusWe     <= i_MemWrite;
            lane_off    <= i_ALUResult[1:0];
            funct3_q    <= i_Funct3;
            o_BusReq    <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (i_BusAck) begin
            if (!o_BusWe)
              o_ReadData <= load_value;
            o_BusReq <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit.
//
// The stimulus process drives each access and pushes the expected outcome
// into a queue. The monitor runs on the falling edge. It pops an entry when
// a transaction completes, meaning o_BusReq falls without a reset, or when
// a fault is flagged. It then compares the latched bus fields, the load
// result, the error flag and the number of stall cycles.
//
// The timeout scenarios only run when LSU_TIMEOUT_EN is defined.

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_ALUResult;
  logic [31:0] i_WriteData;
  logic        i_MemRead;
  logic        i_MemWrite;
  logic [2:0]  i_Funct3;
  logic [31:0] o_ReadData;
  logic        o_Stall;
  logic        o_MisalignedFault;
  logic        o_BusError;
  logic        o_BusReq;
  logic        o_BusWe;
  logic [31:0] o_BusAddr;
  logic [31:0] o_BusWData;
  logic [3:0]  o_BusByteEn;
  logic        i_BusAck;
  logic [31:0] i_BusRData;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_ALUResult      (i_ALUResult),
    .i_WriteData      (i_WriteData),
    .i_MemRead        (i_MemRead),
    .i_MemWrite       (i_MemWrite),
    .i_Funct3         (i_Funct3),
    .o_ReadData       (o_ReadData),
    .o_Stall          (o_Stall),
    .o_MisalignedFault(o_MisalignedFault),
    .o_BusError       (o_BusError),
    .o_BusReq         (o_BusReq),
    .o_BusWe          (o_BusWe),
    .o_BusAddr        (o_BusAddr),
    .o_BusWData       (o_BusWData),
    .o_BusByteEn      (o_BusByteEn),
    .i_BusAck         (i_BusAck),
    .i_BusRData       (i_BusRData)
  );

  typedef struct {
    logic        is_fault;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stalls;
    logic        berr;
  } exp_t;

  exp_t exp_q[$];
  int   check_count = 0;
  int   pass_count  = 0;

  // One comparison: count it, and report a failure with both values.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  function automatic exp_t mkAccess(input logic [31:0] addr, input logic [3:0] be,
                                    input logic we, input logic [31:0] wdata,
                                    input logic [31:0] rdata, input int stalls,
                                    input logic berr);
    exp_t e;
    e.is_fault = 1'b0; e.addr = addr; e.be = be; e.we = we; e.wdata = wdata;
    e.rdata = rdata; e.stalls = stalls; e.berr = berr;
    return e;
  endfunction

  // Monitor: counts stall cycles since the last completion or reset. It
  // latches the bus fields while the request is up and checks them once
  // the request drops.
  logic        prev_req = 1'b0;
  int          stall_cnt = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  always @(negedge clk) begin
    exp_t e;
    if (i_rst) begin
      prev_req  = 1'b0;
      stall_cnt = 0;
    end else begin
      if (o_MisalignedFault) begin
        if (exp_q.size() == 0) begin
          check_count++;
          $display("[TB] FAIL unexpected_fault: got fault with empty scoreboard, expected none");
        end else begin
          e = exp_q.pop_front();
          checkOutput("entry_is_fault", 32'(e.is_fault), 32'd1);
          checkOutput("fault_stall", 32'(o_Stall), 32'd0);
          checkOutput("fault_busreq", 32'(o_BusReq), 32'd0);
        end
      end else if (prev_req && !o_BusReq) begin
        if (exp_q.size() == 0) begin
          check_count++;
          $display("[TB] FAIL unexpected_completion: got completion with empty scoreboard, expected none");
        end else begin
          e = exp_q.pop_front();
          checkOutput("entry_is_access", 32'(e.is_fault), 32'd0);
          checkOutput("bus_addr", cap_addr, e.addr);
          checkOutput("bus_byte_en", 32'(cap_be), 32'(e.be));
          checkOutput("bus_we", 32'(cap_we), 32'(e.we));
          checkOutput("bus_wdata", cap_wdata, e.wdata);
          checkOutput("read_data", o_ReadData, e.rdata);
          checkOutput("bus_error", 32'(o_BusError), 32'(e.berr));
          checkOutput("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
          checkOutput("done_stall", 32'(o_Stall), 32'd0);
        end
        stall_cnt = 0;
      end else if (o_Stall) begin
        stall_cnt++;
      end
      if (o_BusReq) begin
        cap_addr  = o_BusAddr;
        cap_wdata = o_BusWData;
        cap_be    = o_BusByteEn;
        cap_we    = o_BusWe;
      end
      prev_req = o_BusReq;
    end
  end

  // Runs one access from IDLE through DONE. Ack is given in REQ cycle
  // ack_after (0 = first REQ cycle). A negative value means never ack.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input int ack_after, input logic [31:0] rdata);
    bit done = 1'b0;
    i_MemRead = rd; i_MemWrite = wr; i_Funct3 = f3;
    i_ALUResult = addr; i_WriteData = wd;
    @(posedge clk); #1;
    for (int c = 0; c < 40; c++) begin
      if (!o_BusReq) begin
        done = 1'b1;
        break;
      end
      i_BusAck   = (c == ack_after);
      i_BusRData = rdata;
      @(posedge clk); #1;
      i_BusAck = 1'b0;
    end
    if (!done) begin
      check_count++;
      $display("[TB] FAIL bus_handshake_bound: got request still pending after 40 cycles, expected completion");
      i_rst = 1'b1;
      @(posedge clk); #1;
      i_rst = 1'b0;
    end
    @(posedge clk); #1;
    i_MemRead = 1'b0; i_MemWrite = 1'b0;
    @(posedge clk); #1;
  endtask

  // Presents an illegal access for one cycle. Expects a fault and no request.
  task automatic applyFault(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr);
    exp_t e;
    e = mkAccess(32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    e.is_fault = 1'b1;
    exp_q.push_back(e);
    i_MemRead = rd; i_MemWrite = wr; i_Funct3 = f3; i_ALUResult = addr;
    @(posedge clk); #1;
    checkOutput("fault_no_request", 32'(o_BusReq), 32'd0);
    i_MemRead = 1'b0; i_MemWrite = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rst = 1'b1; i_ALUResult = '0; i_WriteData = '0; i_MemRead = 1'b0;
    i_MemWrite = 1'b0; i_Funct3 = 3'b000; i_BusAck = 1'b0; i_BusRData = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busreq", 32'(o_BusReq), 32'd0);
    checkOutput("rst_buswe", 32'(o_BusWe), 32'd0);
    checkOutput("rst_buserror", 32'(o_BusError), 32'd0);
    checkOutput("rst_busaddr", o_BusAddr, 32'h0);
    checkOutput("rst_buswdata", o_BusWData, 32'h0);
    checkOutput("rst_readdata", o_ReadData, 32'h0);
    checkOutput("rst_byteen", 32'(o_BusByteEn), 32'd0);
    checkOutput("rst_stall", 32'(o_Stall), 32'd0);
    i_rst = 1'b0;
    @(posedge clk); #1;

    // LW 0x100, ack immediately
    exp_q.push_back(mkAccess(32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF, 2, 1'b0));
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    // LB / LBU on the top byte lane
    exp_q.push_back(mkAccess(32'h200, 4'b1000, 1'b0, 32'h0, 32'hFFFFFF80, 2, 1'b0));
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80112233);
    exp_q.push_back(mkAccess(32'h200, 4'b1000, 1'b0, 32'h0, 32'h00000080, 2, 1'b0));
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80112233);
    // SH 0x302 with three wait cycles; ReadData must stay at the LBU result
    exp_q.push_back(mkAccess(32'h300, 4'b1100, 1'b1, 32'hABCDABCD, 32'h00000080, 5, 1'b0));
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h302, 32'h0000ABCD, 3, 32'hFFFFFFFF);
    // LH upper half (sign), LHU lower half (zero)
    exp_q.push_back(mkAccess(32'h200, 4'b1100, 1'b0, 32'h0, 32'hFFFF8001, 2, 1'b0));
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 0, 32'h80011234);
    exp_q.push_back(mkAccess(32'h000, 4'b0011, 1'b0, 32'h0, 32'h0000F00D, 2, 1'b0));
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h000, 32'h0, 0, 32'h1234F00D);
    // SB lane 1 with one wait cycle
    exp_q.push_back(mkAccess(32'h500, 4'b0010, 1'b1, 32'hA5A5A5A5, 32'h0000F00D, 3, 1'b0));
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h501, 32'h123456A5, 1, 32'h0);
    // LB lane 1, positive byte
    exp_q.push_back(mkAccess(32'h000, 4'b0010, 1'b0, 32'h0, 32'h0000007F, 2, 1'b0));
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h001, 32'h0, 0, 32'h00007F00);
    // SW
    exp_q.push_back(mkAccess(32'h10C, 4'b1111, 1'b1, 32'h12345678, 32'h0000007F, 2, 1'b0));
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h10C, 32'h12345678, 0, 32'h0);

    // Illegal and misaligned accesses
    applyFault(1'b1, 1'b0, 3'b010, 32'h101);
    applyFault(1'b0, 1'b1, 3'b001, 32'h305);
    applyFault(1'b1, 1'b1, 3'b010, 32'h100);
    applyFault(1'b0, 1'b1, 3'b100, 32'h100);
    applyFault(1'b1, 1'b0, 3'b011, 32'h100);
    applyFault(1'b1, 1'b0, 3'b101, 32'h203);
    checkOutput("readdata_after_faults", o_ReadData, 32'h0000007F);

    // Reset in the middle of a store, followed by a late ack
    i_MemWrite = 1'b1; i_Funct3 = 3'b010; i_ALUResult = 32'h400; i_WriteData = 32'h12345678;
    @(posedge clk); #1;
    checkOutput("rst_mid_req_up", 32'(o_BusReq), 32'd1);
    i_rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid_busreq", 32'(o_BusReq), 32'd0);
    checkOutput("rst_mid_readdata", o_ReadData, 32'h0);
    i_rst = 1'b0; i_MemWrite = 1'b0; i_BusAck = 1'b1; i_BusRData = 32'hFFFFFFFF;
    @(posedge clk); #1;
    i_BusAck = 1'b0;
    checkOutput("late_ack_busreq", 32'(o_BusReq), 32'd0);
    checkOutput("late_ack_stall", 32'(o_Stall), 32'd0);
    checkOutput("late_ack_readdata", o_ReadData, 32'h0);
    @(posedge clk); #1;
    checkOutput("late_ack_still_idle", 32'(o_BusReq), 32'd0);

    // Recovery after reset
    exp_q.push_back(mkAccess(32'h010, 4'b1111, 1'b0, 32'h0, 32'h0BADF00D, 2, 1'b0));
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h010, 32'h0, 0, 32'h0BADF00D);

`ifdef LSU_TIMEOUT_EN
    // No ack: aborted after four REQ cycles
    exp_q.push_back(mkAccess(32'h600, 4'b1111, 1'b0, 32'h0, 32'h0, 5, 1'b1));
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, -1, 32'h55555555);
    checkOutput("buserror_pulse_end", 32'(o_BusError), 32'd0);
    // Ack on the limit cycle completes normally
    exp_q.push_back(mkAccess(32'h600, 4'b1111, 1'b0, 32'h0, 32'hCAFEF00D, 5, 1'b0));
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 3, 32'hCAFEF00D);
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the ALU in the RISC-V datapath. It takes the ALU result as the effective address for loads and stores, and the rs2 value as store data. It runs a request/acknowledge transaction on the data-memory bus, handles byte/halfword/word lanes with sign or zero extension, and stalls the core until the access completes. Misaligned or illegal accesses are flagged without touching the bus.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum REQ cycles before abort; used only when the timeout feature is compiled in.

Ports:
- i_clk  input  1  single clock; all state changes on rising edge.
- i_rst  input  1  reset, synchronous and active-high.
- i_ALUResult  input  32  effective byte address.
- i_WriteData  input  32  store data (rs2).
- i_MemRead  input  1  load instruction present.
- i_MemWrite  input  1  store instruction present.
- i_Funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- o_ReadData  output  32  extended load result, registered.
- o_Stall  output  1  holds PC/instruction while access pending.
- o_MisalignedFault  output  1  misaligned or illegal access this cycle.
- o_BusError  output  1  access aborted by timeout; one-cycle pulse.
- o_BusReq  output  1  bus request.
- o_BusWe  output  1  1 = write.
- o_BusAddr  output  32  word-aligned address ({addr[31:2],2'b00}).
- o_BusWData  output  32  lane-replicated store data.
- o_BusByteEn  output  4  active byte lanes.
- i_BusAck  input  1  transaction complete; read data valid same cycle.
- i_BusRData  input  32  read word.

## Operation
- FSM states: IDLE, REQ, DONE. Reset → IDLE.
- Access = i_MemRead ^ i_MemWrite. Both high is illegal.
- Illegal access conditions:
  - Both i_MemRead and i_MemWrite high.
  - Store funct3 not in {000,001,010}.
  - Load funct3 not in {000,001,010,100,101}.
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
- Illegal access in IDLE: o_MisalignedFault=1 combinationally, no stall, no bus request, o_ReadData unchanged, stays IDLE.
- Legal access in IDLE: register address, byte enables, write data and We; assert o_BusReq; go to REQ.
- Byte enables:
  - B/BU: 4'b0001<<addr[1:0].
  - H/HU: 4'b0011<<addr[1:0].
  - W: 4'b1111.
- Store data:
  - SB: {4{wd[7:0]}}.
  - SH: {2{wd[15:0]}}.
  - SW: wd.
- REQ: bus outputs held stable until i_BusAck=1 is sampled at a rising edge.
  - On ack: for a load, capture the extracted lane into o_ReadData. B/H sign-extend bit 7/15; BU/HU zero-extend.
  - On ack: drop o_BusReq and go to DONE.
- DONE: one cycle. The core advances past the instruction at the end of this cycle; then → IDLE.
- o_Stall = legal access AND state≠DONE (combinational).
- i_BusAck outside REQ is ignored.
- Reset mid-transaction: at the next edge, state → IDLE and o_BusReq → 0. A late ack is ignored.
- Stores leave o_ReadData unchanged.

## Timing
- Reset values:
  - o_BusReq, o_BusWe, o_BusError: 0.
  - o_BusAddr, o_BusWData, o_ReadData: 0.
  - o_BusByteEn: 4'b0000.
- Minimum latency with ack in the first REQ cycle: IDLE (stall) → REQ+ack (stall) → DONE (no stall). That is 2 stall cycles, 3 cycles per access.
- Each additional wait cycle on i_BusAck adds one stall cycle.
- o_ReadData is valid from the start of DONE until the next completed load or reset.
- o_MisalignedFault is combinational and only asserts in IDLE.

## Configuration
- LSU_TIMEOUT_EN defined:
  - An 8+ bit counter (sized for TIMEOUT_CYCLES) clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: drop o_BusReq, o_ReadData ← 0, o_BusError=1 during DONE, go to DONE.
  - Ack in the same cycle as the limit takes priority; it is a normal completion.
- LSU_TIMEOUT_EN undefined: no counter, REQ waits indefinitely, o_BusError tied 0.

## Test plan
- LW, addr 0x100, ack in first REQ cycle, rdata 0xDEADBEEF → BusAddr 0x100, ByteEn 1111, 2 stall cycles, ReadData 0xDEADBEEF in DONE.
- LB addr 0x203 and LBU addr 0x203, rdata 0x80112233 → ByteEn 1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH addr 0x302, wd 0x0000ABCD, ack after 3 wait cycles → BusWe 1, ByteEn 1100, WData 0xABCDABCD, 5 stall cycles.
- LW addr 0x101; SH addr 0x305; MemRead=MemWrite=1 → MisalignedFault 1, Stall 0, BusReq never asserted.
- i_rst asserted during REQ of a write, ack arrives next cycle → BusReq 0 after the edge, state IDLE, ack ignored, ReadData 0.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → BusReq drops after 4 REQ cycles, BusError pulses 1 cycle, ReadData 0; rerun with ack on the 4th cycle → normal completion, BusError 0.
